// File: rtl/asic_rrsched.sv
// asic_rrsched: round-robin scheduler that grants one shared resource to one of
// N requesters for a multi-cycle transaction, with back-to-back handoff and a watchdog.
module asic_rrsched #(
    parameter int N      = 4,
    parameter int MAXCYC = 16,
    parameter     PROP   = "DEFAULT"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IDW  = $clog2(N);
    localparam int CW   = (MAXCYC > 1) ? $clog2(MAXCYC) : 1;
    localparam int CMAX = (MAXCYC > 0) ? MAXCYC - 1 : 0;

    if (N < 2) begin : g_bad_n
        $error("asic_rrsched: N must be at least 2");
    end

    // PROP is only forwarded to library cells; an empty tag is a configuration error.
    if (PROP == "") begin : g_bad_prop
        $error("asic_rrsched: PROP must not be empty");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] nxt_ptr_s;
    logic [IDW-1:0] arb_ptr_s;
    logic [IDW:0]   pick_s;
    logic           win_vld_s;
    logic [IDW-1:0] win_id_s;
    logic [N-1:0]   win_oh_s;
    logic           own_req_s;
    logic           wd_hit_s;
    logic           release_s;

    // First set bit of r scanning p, p+1, ... wrapping; result is {valid, index}.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IDW'((int'(p) + i) % N);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Arbitration: on a release the owner's successor leads, so the owner ranks last.
    always_comb begin
        nxt_ptr_s = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
        arb_ptr_s = (state_q == ST_GRANT) ? nxt_ptr_s : ptr_q;
        pick_s    = rr_pick(req, arb_ptr_s);
        win_vld_s = pick_s[IDW];
        win_id_s  = pick_s[IDW-1:0];
        win_oh_s  = {{(N-1){1'b0}}, 1'b1} << win_id_s;
        own_req_s = req[gnt_id_q];
        wd_hit_s  = (MAXCYC != 0) && (cnt_q == CW'(CMAX)) && !done;
        release_s = done || !own_req_s || wd_hit_s;
    end

    // Next-state logic for ownership, rotation pointer, watchdog count and outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_d  = ST_GRANT;
                    gnt_d    = win_oh_s;
                    gnt_id_d = win_id_s;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    ptr_d     = nxt_ptr_s;
                    cnt_d     = '0;
                    timeout_d = wd_hit_s;
                    if (win_vld_s) begin
                        state_d  = ST_GRANT;
                        gnt_d    = win_oh_s;
                        gnt_id_d = win_id_s;
                        busy_d   = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        busy_d   = 1'b0;
                    end
                end else if (cnt_q != CW'(CMAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_asic_rrsched.sv
// Self-checking bench for asic_rrsched (N=4, MAXCYC=16): per-scenario step tables,
// expected outputs queued when a step is driven and compared after the clock edge.
module tb_asic_rrsched;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       t;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] r;
        logic       d;
        obs_t       e;
    } step_t;

    obs_t exp_q[$];

    asic_rrsched #(.N(4), .MAXCYC(16), .PROP("DEFAULT")) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic rst, input logic [3:0] r, input logic d,
                                 input logic [3:0] g, input logic [1:0] id,
                                 input logic b, input logic t);
        step_t s;
        s.rst  = rst;
        s.r    = r;
        s.d    = d;
        s.e.g  = g;
        s.e.id = id;
        s.e.b  = b;
        s.e.t  = t;
        return s;
    endfunction

    task automatic test_reset();
        step_t s[$];
        obs_t  e, got;
        s.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(mk(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req = s[i].r; done = s[i].d;
            exp_q.push_back(s[i].e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = {gnt, gnt_id, busy, timeout};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got gnt=%b id=%0d busy=%b to=%b, required gnt=%b id=%0d busy=%b to=%b",
                         i, got.g, got.id, got.b, got.t, e.g, e.id, e.b, e.t);
            end
        end
    endtask

    task automatic test_rotation();
        step_t      s[$];
        obs_t       e, got;
        logic [3:0] one = 4'b0001;
        logic [1:0] cur, nxt;
        for (int k = 0; k < 4; k++) begin
            cur = 2'(k);
            nxt = 2'((k + 1) % 4);
            s.push_back(mk(1'b0, 4'b1111, 1'b0, one << cur, cur, 1'b1, 1'b0));
            s.push_back(mk(1'b0, 4'b1111, 1'b0, one << cur, cur, 1'b1, 1'b0));
            s.push_back(mk(1'b0, 4'b1111, 1'b1, one << nxt, nxt, 1'b1, 1'b0));
        end
        s.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req = s[i].r; done = s[i].d;
            exp_q.push_back(s[i].e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = {gnt, gnt_id, busy, timeout};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rotation[%0d]: got gnt=%b id=%0d busy=%b to=%b, required gnt=%b id=%0d busy=%b to=%b",
                         i, got.g, got.id, got.b, got.t, e.g, e.id, e.b, e.t);
            end
        end
    endtask

    task automatic test_single();
        step_t s[$];
        obs_t  e, got;
        s.push_back(mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req = s[i].r; done = s[i].d;
            exp_q.push_back(s[i].e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = {gnt, gnt_id, busy, timeout};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single[%0d]: got gnt=%b id=%0d busy=%b to=%b, required gnt=%b id=%0d busy=%b to=%b",
                         i, got.g, got.id, got.b, got.t, e.g, e.id, e.b, e.t);
            end
        end
    endtask

    // Pointer is 3 on entry; a reset that failed to clear it would favour requester 3.
    task automatic test_mid_reset();
        step_t s[$];
        obs_t  e, got;
        s.push_back(mk(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        s.push_back(mk(1'b1, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        s.push_back(mk(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req = s[i].r; done = s[i].d;
            exp_q.push_back(s[i].e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = {gnt, gnt_id, busy, timeout};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mid_reset[%0d]: got gnt=%b id=%0d busy=%b to=%b, required gnt=%b id=%0d busy=%b to=%b",
                         i, got.g, got.id, got.b, got.t, e.g, e.id, e.b, e.t);
            end
        end
    endtask

    task automatic test_watchdog();
        step_t s[$];
        obs_t  e, got;
        for (int k = 0; k <= 32; k++) begin
            s.push_back(mk(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, (k == 16 || k == 32)));
        end
        s.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0));
        for (int k = 0; k < 16; k++) begin
            s.push_back(mk(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0));
        end
        s.push_back(mk(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req = s[i].r; done = s[i].d;
            exp_q.push_back(s[i].e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = {gnt, gnt_id, busy, timeout};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL watchdog[%0d]: got gnt=%b id=%0d busy=%b to=%b, required gnt=%b id=%0d busy=%b to=%b",
                         i, got.g, got.id, got.b, got.t, e.g, e.id, e.b, e.t);
            end
        end
    endtask

    task automatic test_abort();
        step_t s[$];
        obs_t  e, got;
        s.push_back(mk(1'b0, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0));
        s.push_back(mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (s[i]) begin
            reset = s[i].rst; req = s[i].r; done = s[i].d;
            exp_q.push_back(s[i].e);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = {gnt, gnt_id, busy, timeout};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL abort[%0d]: got gnt=%b id=%0d busy=%b to=%b, required gnt=%b id=%0d busy=%b to=%b",
                         i, got.g, got.id, got.b, got.t, e.g, e.id, e.b, e.t);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        test_reset();
        test_rotation();
        test_single();
        test_mid_reset();
        test_watchdog();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/asic_rrsched.md
Name: asic_rrsched

Overview:
- Round-robin scheduler granting exclusive, multi-cycle ownership of one shared resource to N requesters.
- Typical shared resources: a combinational datapath built from asiclib cells, or a shared bus/port.
- Outputs are registered: one-hot grant, binary owner id, busy, and a watchdog timeout pulse.
- Sits between requesting agents and the resource mux select / enable.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAXCYC, 16, watchdog limit in cycles per ownership; 0 disables the watchdog.
- PROP, "DEFAULT", implementation property string passed through to library cells.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; held high until granted and for the whole transaction.
- done  input  1  current owner's final cycle; ignored when busy=0.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_id  output  $clog2(N)  binary index of current owner; holds last value when idle.
- busy  output  1  registered; equals |gnt.
- timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (sampled on clk edge while reset=1):
  - gnt=0, gnt_id=0, busy=0, timeout=0, pointer ptr=0, watchdog count=0, state IDLE.
  - Reset overrides all other inputs, including mid-transaction: the grant drops on the next edge with no timeout pulse.
- State IDLE (busy=0):
  - If any req bit is high, the winner is the first set bit scanning ptr, ptr+1, ... N-1, 0, ... ptr-1.
  - Next edge: gnt=onehot(winner), gnt_id=winner, count=0, state GRANT.
  - Request-to-grant latency is 1 cycle.
  - If no req bit is high, all state holds.
- State GRANT (owner = gnt_id). Release occurs on any of:
  - (a) done=1;
  - (b) req[owner]=0 (abort);
  - (c) MAXCYC != 0, count == MAXCYC-1, and done=0 (watchdog).
- On a release cycle:
  - ptr_next = (owner+1) mod N, so the owner becomes lowest priority.
  - Arbitration uses ptr_next and the current req vector. The owner's own req is included but has lowest priority.
  - If a winner exists: next edge gnt=onehot(winner), gnt_id=winner, count=0, state stays GRANT. There is no idle gap (back-to-back handoff).
  - If no winner: next edge gnt=0, state IDLE, gnt_id holds.
  - For case (c) only, timeout=1 on that same next edge, for exactly one cycle. If done=1 on the limit cycle, it is a normal release with no timeout.
- When not releasing: count increments each cycle; it saturates at MAXCYC-1 (irrelevant when MAXCYC=0).
- ptr updates only on release. It wraps from N-1 to 0.
- New req bits arriving mid-grant have no effect until release.
- gnt is always one-hot or zero. gnt and gnt_id never disagree while busy=1.
- Implementation size: about 150 lines of RTL.

Test Plan:
- Reset check: after reset with req=4'b1111 held, all outputs are 0 during reset. First edge after reset deasserts: gnt=0001, gnt_id=0, busy=1.
- Rotation (N=4, req=1111, done pulsed once per grant, 3 cycles after each grant): grants in order 0,1,2,3,0. Each handoff is back-to-back with busy continuously 1.
- Single requester (req=0100, done at grant+2): gnt=0100 for 3 cycles, then 0000 and busy=0. Re-asserting req=0100 regrants it 1 cycle later; owner is not starved.
- Watchdog (MAXCYC=16, req=0010 held, done never): gnt=0010 for exactly 16 cycles. Next edge: timeout=1 for one cycle, and gnt=0010 again (sole requester regranted), count restarted.
- Abort: owner 2 drops req while req[3]=1. Next edge gnt=1000, timeout=0.
- Mid-grant reset: reset asserted during ownership of requester 1 forces gnt=0 and ptr=0 on the next edge. After release of reset with req=1010, the first grant goes to requester 1.
